// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions: parameter defaults, metric width
// derivation and the per-symbol branch distance used by every BMC flavour.
package viterbi_pkg;

    localparam int CODE_N_DEF = 2;
    localparam int SOFT_W_DEF = 3;
    localparam int SYM_MAX_W  = 8;

    // Metric width that holds CODE_N maximal symbol distances without overflow.
    function automatic int metric_w(input int code_n, input int soft_w);
        return soft_w + $clog2(code_n + 1);
    endfunction

    // Distance of one received symbol to an expected code bit.
    // Soft: expected 0 -> r, expected 1 -> full-scale minus r.
    // Hard: MSB of r XOR expected bit. Punctured symbols contribute nothing.
    function automatic logic [SYM_MAX_W-1:0] sym_dist(
        input logic [SYM_MAX_W-1:0] r,
        input int                   soft_w,
        input logic                 exp_bit,
        input logic                 hard,
        input logic                 erased
    );
        logic [SYM_MAX_W-1:0] full;
        logic                 hard_bit;
        full     = SYM_MAX_W'((1 << soft_w) - 1);
        hard_bit = |(r & (SYM_MAX_W'(1) << (soft_w - 1)));
        if (erased)
            return '0;
        if (hard)
            return {{(SYM_MAX_W-1){1'b0}}, hard_bit ^ exp_bit};
        return exp_bit ? (full - r) : r;
    endfunction

endpackage

// File: rtl/bmc_soft_pipe_if.sv
// Beat-level bus between the symbol source, the branch metric unit and the
// ACS array: input handshake with codeword/erasures, output handshake with metrics.
interface bmc_soft_pipe_if
    import viterbi_pkg::*;
#(
    parameter int CODE_N = CODE_N_DEF,
    parameter int SOFT_W = SOFT_W_DEF
);
    localparam int MW = metric_w(CODE_N, SOFT_W);

    logic                          hard_mode;
    logic                          in_valid;
    logic                          in_ready;
    logic [CODE_N*SOFT_W-1:0]      rx_sym;
    logic [CODE_N-1:0]             erase;
    logic                          out_valid;
    logic                          out_ready;
    logic [(2**CODE_N)*MW-1:0]     bm;
    logic                          out_last;

    modport master (
        output hard_mode, in_valid, rx_sym, erase, out_ready,
        input  in_ready, out_valid, bm, out_last
    );

    modport slave (
        input  hard_mode, in_valid, rx_sym, erase, out_ready,
        output in_ready, out_valid, bm, out_last
    );

endinterface

// File: rtl/bmc_sym_dist.sv
// One received symbol -> its distances to expected bit 0 and expected bit 1.
module bmc_sym_dist
    import viterbi_pkg::*;
#(
    parameter int SOFT_W = SOFT_W_DEF
) (
    input  logic [SOFT_W-1:0] r,
    input  logic              hard,
    input  logic              erased,
    output logic [SOFT_W-1:0] d0,
    output logic [SOFT_W-1:0] d1
);

    // Both hypotheses evaluated in parallel; results always fit in SOFT_W bits.
    always_comb begin
        d0 = SOFT_W'(sym_dist(SYM_MAX_W'(r), SOFT_W, 1'b0, hard, erased));
        d1 = SOFT_W'(sym_dist(SYM_MAX_W'(r), SOFT_W, 1'b1, hard, erased));
    end

endmodule

// File: rtl/bmc_soft_pipe.sv
// Two-stage branch metric unit: stage 1 holds per-symbol distance pairs,
// stage 2 holds the summed metric of every expected codeword plus frame tag.
module bmc_soft_pipe
    import viterbi_pkg::*;
#(
    parameter int CODE_N    = CODE_N_DEF,
    parameter int SOFT_W    = SOFT_W_DEF,
    parameter int FRAME_LEN = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    bmc_soft_pipe_if.slave     bus
);

    localparam int MW    = metric_w(CODE_N, SOFT_W);
    localparam int NH    = 2**CODE_N;
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic [CODE_N-1:0][SOFT_W-1:0] d0_w;
    logic [CODE_N-1:0][SOFT_W-1:0] d1_w;
    logic [CODE_N-1:0][SOFT_W-1:0] s1_d0;
    logic [CODE_N-1:0][SOFT_W-1:0] s1_d1;
    logic                          s1_v;
    logic                          s1_last;
    logic                          s2_v;
    logic                          s2_last;
    logic [NH*MW-1:0]              s2_bm;
    logic [NH*MW-1:0]              sum_next;
    logic [MW-1:0]                 acc;
    logic [CNT_W-1:0]              frame_cnt;
    logic                          ld1;
    logic                          ld2;

    for (genvar g = 0; g < CODE_N; g++) begin : g_sym
        bmc_sym_dist #(.SOFT_W(SOFT_W)) u_sym_dist (
            .r      (bus.rx_sym[g*SOFT_W +: SOFT_W]),
            .hard   (bus.hard_mode),
            .erased (bus.erase[g]),
            .d0     (d0_w[g]),
            .d1     (d1_w[g])
        );
    end

    // Handshake: stage 2 refills when empty or draining; stage 1 accepts when it can move on.
    always_comb begin
        ld2 = s1_v & (!s2_v | bus.out_ready);
        ld1 = bus.in_valid & (!s1_v | ld2);
    end

    assign bus.in_ready  = !s1_v | ld2;
    assign bus.out_valid = s2_v;
    assign bus.bm        = s2_bm;
    assign bus.out_last  = s2_last;

    // Frame position of the next accepted beat; only accepted beats advance it.
    always_ff @(posedge clk) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (ld1)
            frame_cnt <= (frame_cnt == LAST_CNT) ? '0 : frame_cnt + CNT_W'(1);
    end

    // Stage 1 captures the distance pairs and the frame tag of the accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_d0   <= '0;
            s1_d1   <= '0;
            s1_last <= 1'b0;
        end else begin
            if (ld1) begin
                s1_d0   <= d0_w;
                s1_d1   <= d1_w;
                s1_last <= (frame_cnt == LAST_CNT);
            end
            if (ld1)
                s1_v <= 1'b1;
            else if (ld2)
                s1_v <= 1'b0;
        end
    end

    // Sum, for each hypothesis h, the distance selected by each bit of h.
    always_comb begin
        sum_next = '0;
        acc      = '0;
        for (int h = 0; h < NH; h++) begin
            acc = '0;
            for (int i = 0; i < CODE_N; i++) begin
                if (((h >> i) & 1) != 0)
                    acc = acc + MW'(s1_d1[i]);
                else
                    acc = acc + MW'(s1_d0[i]);
            end
            sum_next[h*MW +: MW] = acc;
        end
    end

    // Stage 2 holds metrics steady until the ACS array takes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_bm   <= '0;
            s2_last <= 1'b0;
        end else if (ld2) begin
            s2_v    <= 1'b1;
            s2_bm   <= sum_next;
            s2_last <= s1_last;
        end else if (bus.out_ready) begin
            s2_v    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Directed bench for bmc_soft_pipe with CODE_N=2, SOFT_W=3, FRAME_LEN=4.
module tb_bmc_soft_pipe;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [5:0]  rx_tab   [5];
    logic [19:0] bm_tab   [5];
    logic        last_tab [5];

    bmc_soft_pipe_if #(.CODE_N(2), .SOFT_W(3)) bus ();

    bmc_soft_pipe #(.CODE_N(2), .SOFT_W(3), .FRAME_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.hard_mode = 1'b0;
        bus.erase     = '0;
        bus.rx_sym    = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_last: got %0b expected 0", bus.out_last); end
        n_cmp++; if (bus.bm !== 20'h0) begin n_err++; $display("[TB] FAIL reset_bm: got %0h expected 0", bus.bm); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    endtask

    task automatic test_hard();
        do_reset();
        bus.hard_mode = 1'b1;
        bus.rx_sym    = {3'b100, 3'b100};
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.hard_mode = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL hard_latency1: got %0b expected 0", bus.out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL hard_latency2: got %0b expected 1", bus.out_valid); end
        n_cmp++; if (bus.bm !== {5'd0, 5'd1, 5'd1, 5'd2}) begin n_err++; $display("[TB] FAIL hard_bm: got %0h expected %0h", bus.bm, {5'd0, 5'd1, 5'd1, 5'd2}); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("[TB] FAIL hard_last: got %0b expected 0", bus.out_last); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL hard_drain: got %0b expected 0", bus.out_valid); end
    endtask

    task automatic test_soft();
        do_reset();
        bus.rx_sym   = {3'd7, 3'd0};
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL soft_valid: got %0b expected 1", bus.out_valid); end
        n_cmp++; if (bus.bm !== {5'd7, 5'd0, 5'd14, 5'd7}) begin n_err++; $display("[TB] FAIL soft_bm: got %0h expected %0h", bus.bm, {5'd7, 5'd0, 5'd14, 5'd7}); end
    endtask

    task automatic test_erase();
        do_reset();
        bus.rx_sym   = {3'd7, 3'd0};
        bus.erase    = 2'b10;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.erase    = 2'b00;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL erase_valid: got %0b expected 1", bus.out_valid); end
        n_cmp++; if (bus.bm !== {5'd7, 5'd0, 5'd7, 5'd0}) begin n_err++; $display("[TB] FAIL erase_bm: got %0h expected %0h", bus.bm, {5'd7, 5'd0, 5'd7, 5'd0}); end
    endtask

    task automatic test_stall();
        do_reset();
        fork
            begin
                int   k;
                int   guard;
                logic rdy;
                k = 0;
                guard = 0;
                while (k < 5 && guard < 50) begin
                    bus.in_valid = 1'b1;
                    bus.rx_sym   = rx_tab[k];
                    @(negedge clk);
                    rdy = bus.in_ready;
                    @(posedge clk); #1;
                    if (rdy) k++;
                    guard++;
                end
                bus.in_valid = 1'b0;
            end
            begin
                int n;
                int c;
                n = 0;
                c = 0;
                while (n < 5 && c < 60) begin
                    bus.out_ready = (c >= 2 && c < 6) ? 1'b0 : 1'b1;
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) begin
                        n_cmp++; if (bus.bm !== bm_tab[n]) begin n_err++; $display("[TB] FAIL stall_bm beat %0d: got %0h expected %0h", n, bus.bm, bm_tab[n]); end
                        n_cmp++; if (bus.out_last !== last_tab[n]) begin n_err++; $display("[TB] FAIL stall_last beat %0d: got %0b expected %0b", n, bus.out_last, last_tab[n]); end
                        n++;
                    end else if (c >= 2 && c < 6) begin
                        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL stall_in_ready cycle %0d: got %0b expected 0", c, bus.in_ready); end
                        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL stall_out_valid cycle %0d: got %0b expected 1", c, bus.out_valid); end
                        n_cmp++; if (bus.bm !== bm_tab[0]) begin n_err++; $display("[TB] FAIL stall_hold cycle %0d: got %0h expected %0h", c, bus.bm, bm_tab[0]); end
                    end
                    @(posedge clk); #1;
                    c++;
                end
                n_cmp++; if (n != 5) begin n_err++; $display("[TB] FAIL stall_count: got %0d expected 5", n); end
                bus.out_ready = 1'b1;
            end
        join
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL stall_no_dup: got %0b expected 0", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_frame();
        logic [8:0] last_exp;
        last_exp = 9'b010001000;
        do_reset();
        fork
            begin
                for (int k = 0; k < 9; k++) begin
                    bus.in_valid = 1'b1;
                    bus.rx_sym   = 6'(k);
                    @(posedge clk); #1;
                end
                bus.in_valid = 1'b0;
            end
            begin
                int n;
                int c;
                n = 0;
                c = 0;
                while (n < 9 && c < 40) begin
                    @(negedge clk);
                    if (bus.out_valid) begin
                        n_cmp++; if (c != n + 2) begin n_err++; $display("[TB] FAIL frame_timing beat %0d: got cycle %0d expected %0d", n, c, n + 2); end
                        n_cmp++; if (bus.out_last !== last_exp[n]) begin n_err++; $display("[TB] FAIL frame_last beat %0d: got %0b expected %0b", n, bus.out_last, last_exp[n]); end
                        n++;
                    end
                    @(posedge clk); #1;
                    c++;
                end
                n_cmp++; if (n != 9) begin n_err++; $display("[TB] FAIL frame_count: got %0d expected 9", n); end
            end
        join
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.rx_sym    = rx_tab[0];
        @(posedge clk); #1;
        bus.rx_sym    = rx_tab[1];
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_inflight_valid: got %0b expected 1", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_inflight_ready: got %0b expected 0", bus.in_ready); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_out_valid: got %0b expected 0", bus.out_valid); end
        n_cmp++; if (bus.bm !== 20'h0) begin n_err++; $display("[TB] FAIL midrst_bm: got %0h expected 0", bus.bm); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_in_ready: got %0b expected 1", bus.in_ready); end
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            bus.in_valid = (c < 4);
            bus.rx_sym   = rx_tab[4];
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_valid cycle %0d: got %0b expected 1", c, bus.out_valid); end
                n_cmp++; if (bus.out_last !== (c == 5)) begin n_err++; $display("[TB] FAIL midrst_last cycle %0d: got %0b expected %0b", c, bus.out_last, (c == 5)); end
            end
            if (c == 6) begin
                n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_drain: got %0b expected 0", bus.out_valid); end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rx_tab[0] = {3'd1, 3'd2};  bm_tab[0] = {5'd11, 5'd8,  5'd6,  5'd3};  last_tab[0] = 1'b0;
        rx_tab[1] = {3'd3, 3'd0};  bm_tab[1] = {5'd11, 5'd4,  5'd10, 5'd3};  last_tab[1] = 1'b0;
        rx_tab[2] = {3'd5, 3'd6};  bm_tab[2] = {5'd3,  5'd8,  5'd6,  5'd11}; last_tab[2] = 1'b0;
        rx_tab[3] = {3'd0, 3'd4};  bm_tab[3] = {5'd10, 5'd11, 5'd3,  5'd4};  last_tab[3] = 1'b1;
        rx_tab[4] = {3'd7, 3'd7};  bm_tab[4] = {5'd0,  5'd7,  5'd7,  5'd14}; last_tab[4] = 1'b0;

        test_reset();
        test_hard();
        test_soft();
        test_erase();
        test_stall();
        test_frame();
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
